uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port CLK_I  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_NI  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port FIFO_EMPTY_I  input  1  high when the upstream byte FIFO holds no data.
REQ-005 SHALL have port FIFO_DATA_I  input  8  head byte of the FIFO, combinationally valid whenever FIFO_EMPTY_I is low.
REQ-006 SHALL have port FIFO_RE_O  output  1  one-cycle pop strobe to the FIFO.
REQ-007 SHALL have port TX_O  output  1  serial line, idle high.
REQ-008 SHALL have port BUSY_O  output  1  high in every state other than IDLE.
REQ-009 SHALL have port DONE_O  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-010 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit exactly CLKS_PER_BIT cycles.
REQ-011 SHALL implement states IDLE, START, DATA and STOP, and no others.
REQ-012 IDLE: TX_O=1; if FIFO_EMPTY_I=0, SHALL assert FIFO_RE_O combinationally in that cycle, latch FIFO_DATA_I into the shift register at the edge, and enter START.
REQ-013 SHALL never assert FIFO_RE_O while FIFO_EMPTY_I=1, and never for more than one cycle per byte.
REQ-014 START: TX_O=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-015 DATA: TX_O=shift-register bit 0; every CLKS_PER_BIT cycles shift right and increment the 3-bit index; after index 7 completes, enter STOP.
REQ-016 STOP: TX_O=1 for CLKS_PER_BIT cycles; DONE_O=1 in the final cycle of the stop bit.
REQ-017 In the final STOP cycle with FIFO_EMPTY_I=0, SHALL pop and latch the next byte (as in REQ-012) and go directly to START, with no idle cycle between frames.
REQ-018 In the final STOP cycle with FIFO_EMPTY_I=1, SHALL enter IDLE.
REQ-019 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reset to 0 on every state entry, and count 0..CLKS_PER_BIT-1.
REQ-020 Changes on FIFO_DATA_I after the latch cycle SHALL NOT affect the frame in progress.
REQ-021 TX_O SHALL be driven from a register (glitch-free); first-frame latency from FIFO_EMPTY_I falling in IDLE to TX_O falling SHALL be exactly 1 cycle.

Reset
REQ-022 RST_NI low SHALL immediately, independent of clock, force: state=IDLE, TX_O=1, FIFO_RE_O=0, BUSY_O=0, DONE_O=0, counter=0, bit index=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame without a pop; the first byte after reset release is the FIFO head at that time.

Structure
REQ-024 State enum (uart_tx_state_t) and the frame constants (data bits=8, start/stop levels) SHALL live in shared package uart_pkg.
REQ-025 The baud-period counter SHALL be a sub-module uart_baud_cnt (inputs: clear, enable; output: tick at count CLKS_PER_BIT-1).
REQ-026 The block SHALL connect pin-compatibly to the existing SIMPLE_FIFO: FIFO_EMPTY_I←EMPTY_O, FIFO_DATA_I←R_DATA_O, FIFO_RE_O→RE_I.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: FIFO holds 0x55 -> one FIFO_RE_O pulse; TX_O = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles total); DONE_O pulses at cycle 40; then IDLE with TX_O=1.
REQ-028 Back-to-back: FIFO holds 0xA3, 0x0F -> two frames with no idle gap (80 consecutive cycles); the second start bit begins on the cycle after the first DONE_O.
REQ-029 Empty FIFO: FIFO_EMPTY_I=1 held for 100 cycles -> FIFO_RE_O, BUSY_O and DONE_O stay 0; TX_O stays 1.
REQ-030 Reset mid-frame: RST_NI low during data bit 3 of 0xFF -> TX_O=1 within the same cycle; no further pop until release; the next frame starts cleanly.
REQ-031 Data stability: FIFO_DATA_I toggled randomly after the latch cycle of 0x81 -> the serialized bits still equal 0x81.
REQ-032 Integration with SIMPLE_FIFO (ABITS=2): write 4 bytes until FULL_O -> all 4 transmitted in order; EMPTY_O rises after the 4th pop.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic CLK_I,
    input  logic RST_NI,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && !clear && (cnt == LAST);

    // Wrapping on tick restarts the count at every state entry from a running state.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter pulling bytes from a show-ahead FIFO; back-to-back frames without idle gaps.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       FIFO_EMPTY_I,
    input  logic [7:0] FIFO_DATA_I,
    output logic       FIFO_RE_O,
    output logic       TX_O,
    output logic       BUSY_O,
    output logic       DONE_O
);

    uart_tx_state_t       state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 pop;
    logic                 done;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK_I (CLK_I),
        .RST_NI(RST_NI),
        .clear (state == IDLE),
        .enable(state != IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!FIFO_EMPTY_I) begin
                    pop       = 1'b1;
                    shreg_d   = FIFO_DATA_I;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = shreg >> 1;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    done = 1'b1;
                    if (!FIFO_EMPTY_I) begin
                        pop       = 1'b1;
                        shreg_d   = FIFO_DATA_I;
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so TX_O changes exactly on state edges.
    always_comb begin
        tx_d = IDLE_LVL;
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shreg_d[0];
            STOP:    tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx_q    <= IDLE_LVL;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_idx <= bit_idx_d;
            tx_q    <= tx_d;
        end
    end

    // The pop strobe is combinational from FIFO_EMPTY_I, so reset must mask it directly.
    assign FIFO_RE_O = pop && RST_NI;
    assign DONE_O    = done;
    assign BUSY_O    = (state != IDLE);
    assign TX_O      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx with a queue-backed FIFO and a frame-level waveform model.
module tb_uart_tx;

    localparam int N     = 4;
    localparam int FRAME = 10 * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       re, tx, busy, done;

    byte unsigned q[$];
    logic [3:0]   exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .CLK_I       (clk),
        .RST_NI      (rst_n),
        .FIFO_EMPTY_I(fifo_empty),
        .FIFO_DATA_I (fifo_data),
        .FIFO_RE_O   (re),
        .TX_O        (tx),
        .BUSY_O      (busy),
        .DONE_O      (done)
    );

    // Show-ahead FIFO pins; the data bus carries junk whenever the FIFO is empty.
    task automatic fifo_update();
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? 8'($urandom) : q[0];
    endtask

    // One clock: sample {tx,re,busy,done} mid-cycle, then apply the pop after the edge.
    task automatic step(output logic [3:0] obs);
        logic popped;
        @(negedge clk);
        obs    = {tx, re, busy, done};
        popped = re;
        @(posedge clk);
        #1;
        if (popped && q.size() > 0) q.delete(0);
        fifo_update();
    endtask

    // Expected per-cycle {tx,re,busy,done} when all bytes are queued before cycle 0 and the DUT is idle.
    function automatic void build_expect(input byte unsigned b[$], input int tail);
        int n;
        n = b.size();
        exp_q.delete();
        for (int c = 0; c <= FRAME * n + tail; c++) begin
            logic tx_e, re_e, busy_e, done_e;
            byte unsigned cur;
            int f, k;
            re_e   = (c % FRAME == 0) && (c / FRAME < n);
            done_e = (c > 0) && (c % FRAME == 0) && (c / FRAME <= n);
            busy_e = (c >= 1) && (c <= FRAME * n);
            tx_e   = 1'b1;
            if (busy_e) begin
                f   = (c - 1) / FRAME;
                k   = ((c - 1) % FRAME) / N;
                cur = b[f];
                if (k == 0) tx_e = 1'b0;
                else if (k <= 8) tx_e = cur[k-1];
            end
            exp_q.push_back({tx_e, re_e, busy_e, done_e});
        end
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        q = {8'h5A};
        fifo_update();
        #1 rst_n = 1'b0;
        #1;
        obs = {tx, re, busy, done};
        n_tests++;
        if (obs !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_async {tx,re,busy,done}=%b want 1000", obs);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {tx, re, busy, done};
            n_tests++;
            if (obs !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d {tx,re,busy,done}=%b want 1000", i, obs);
            end
        end
        q.delete();
        fifo_update();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(obs);
    endtask

    task automatic test_empty();
        byte unsigned b[$];
        logic [3:0] obs;
        b = {};
        q = b;
        fifo_update();
        build_expect(b, 99);
        foreach (exp_q[i]) begin
            step(obs);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL empty c=%0d {tx,re,busy,done}=%b want %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_single();
        byte unsigned b[$];
        logic [3:0] obs;
        b = {8'h55};
        q = b;
        fifo_update();
        build_expect(b, 8);
        foreach (exp_q[i]) begin
            step(obs);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single c=%0d {tx,re,busy,done}=%b want %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        byte unsigned b[$];
        logic [3:0] obs;
        b = {8'hA3, 8'h0F};
        q = b;
        fifo_update();
        build_expect(b, 8);
        foreach (exp_q[i]) begin
            step(obs);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d {tx,re,busy,done}=%b want %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_data_stability();
        byte unsigned b[$];
        logic [3:0] obs;
        b = {8'h81};
        q = b;
        fifo_update();
        build_expect(b, 4);
        foreach (exp_q[i]) begin
            step(obs);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL data_stability c=%0d {tx,re,busy,done}=%b want %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        byte unsigned b[$];
        logic [3:0] obs;
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        q = b;
        fifo_update();
        build_expect(b, 6);
        foreach (exp_q[i]) begin
            step(obs);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fifo_full c=%0d {tx,re,busy,done}=%b want %b", i, obs, exp_q[i]);
            end
        end
        n_tests++;
        if (fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fifo_full_drained empty=%b want 1 left=%0d", fifo_empty, q.size());
        end
    endtask

    task automatic test_random();
        byte unsigned b[$];
        logic [3:0] obs;
        for (int it = 0; it < 3; it++) begin
            b.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) b.push_back(8'($urandom));
            q = b;
            fifo_update();
            build_expect(b, 3);
            foreach (exp_q[i]) begin
                step(obs);
                n_tests++;
                if (obs !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random it=%0d c=%0d {tx,re,busy,done}=%b want %b", it, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    // Reset after 'at' cycles of a frame of b0, with a second byte still waiting in the FIFO.
    task automatic test_reset_midframe(input byte unsigned b0, input int at);
        byte unsigned b[$];
        logic [3:0] obs;
        q = {b0, 8'h3C};
        fifo_update();
        for (int i = 0; i < at; i++) step(obs);
        rst_n = 1'b0;
        #1;
        obs = {tx, re, busy, done};
        n_tests++;
        if (obs !== 4'b1000) begin
            n_fail++;
            $display("FAIL midframe_async at=%0d {tx,re,busy,done}=%b want 1000", at, obs);
        end
        for (int i = 0; i < 5; i++) begin
            step(obs);
            n_tests++;
            if (obs !== 4'b1000) begin
                n_fail++;
                $display("FAIL midframe_hold at=%0d c=%0d {tx,re,busy,done}=%b want 1000", at, i, obs);
            end
        end
        rst_n = 1'b1;
        b = {8'h3C};
        n_tests++;
        if (q.size() != 1) begin
            n_fail++;
            $display("FAIL midframe_pops at=%0d fifo_left=%0d want 1", at, q.size());
        end
        build_expect(b, 4);
        foreach (exp_q[i]) begin
            step(obs);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midframe_resume at=%0d c=%0d {tx,re,busy,done}=%b want %b", at, i, obs, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_back_to_back();
        test_data_stability();
        test_fifo_full();
        test_random();
        test_reset_midframe(8'hFF, 18);
        test_reset_midframe(8'h00, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
